nios_altmemddr_0_ex_lfsr_gen_chk: RTL and testbench

Parametrised LFSR pattern generator and checker for the DDR example driver. It produces a Galois LFSR sequence of configurable width, polynomial, seed and shifts-per-clock. In checker mode it tracks read-back data against the same sequence, with optional auto-sync to the first received word. It reports a saturating error count, a sticky error flag and a capture of the first mismatch. It replaces fixed 8-bit LFSR instances on both the write-data and read-compare paths.

---
 rtl/nios_altmemddr_0_ex_lfsr_gen_chk.sv | 89 ++++++++
 tb/tb_nios_altmemddr_0_ex_lfsr_gen_chk.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/nios_altmemddr_0_ex_lfsr_gen_chk.sv
// nios_altmemddr_0_ex_lfsr_gen_chk: Galois LFSR pattern generator and read-back checker with error capture
module nios_altmemddr_0_ex_lfsr_gen_chk #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'h1D),
  parameter logic [63:0]     SEED      = 64'd32,
  parameter int              STEPS     = 1,
  parameter int              CNT_W     = 16,
  parameter bit              AUTO_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] data,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             clr_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [CNT_W-1:0] first_idx
);
  typedef enum logic [1:0] {OFF, SYNC, RUN} state_t;
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  state_t st, st_n;
  logic [WIDTH-1:0] s_n;
  logic cmp, mis;
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
    for (int i = 0; i < STEPS; i++)
      v = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? TAPS : '0);
    return v;
  endfunction
  assign cmp = enable && mode && !load && chk_valid && st == RUN;
  assign mis = chk_data != data;
  always_comb begin
    st_n = st;
    s_n = data;
    if (!enable) begin
      st_n = OFF;
      s_n = SEED_W;
    end else if (load) begin
      st_n = RUN;
      s_n = ldata;
    end else begin
      if (st == OFF) st_n = (mode && AUTO_SYNC) ? SYNC : RUN;
      if (st == SYNC && mode && chk_valid) begin
        st_n = RUN;
        s_n = adv(chk_data);
      end
      if (mode ? (chk_valid && st == RUN) : !pause) s_n = adv(data);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= OFF;
      data <= SEED_W;
    end else begin
      st <= st_n;
      data <= s_n;
    end
  end
  // Error bookkeeping survives enable=0 so results can be read after a run
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      err_flag <= 1'b0;
      err_cnt <= '0;
      word_cnt <= '0;
      first_exp <= '0;
      first_got <= '0;
      first_idx <= '0;
    end else if (cmp) begin
      word_cnt <= word_cnt + CNT_W'(~&word_cnt);
      if (mis) begin
        err_cnt <= err_cnt + CNT_W'(~&err_cnt);
        err_flag <= 1'b1;
        if (!err_flag) begin
          first_exp <= data;
          first_got <= chk_data;
          first_idx <= word_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_nios_altmemddr_0_ex_lfsr_gen_chk.sv
// tb_nios_altmemddr_0_ex_lfsr_gen_chk: directed checks of generator, checker, saturation, load and reset
module tb_nios_altmemddr_0_ex_lfsr_gen_chk;
  logic clk = 0, reset, enable, mode, pause, load, chk_valid, clr_err;
  logic [7:0] ldata, chk_data;
  logic [7:0] d0, d1, d2, fe0, fg0, fe2, fg2;
  logic [15:0] ec0, wc0, fi0, ec1, wc1, fi1;
  logic [3:0] ec2, wc2, fi2;
  logic [7:0] fe1, fg1;
  logic ef0, ef1, ef2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  nios_altmemddr_0_ex_lfsr_gen_chk u0 (.clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .pause(pause), .load(load), .ldata(ldata), .data(d0), .chk_valid(chk_valid), .chk_data(chk_data),
    .clr_err(clr_err), .err_flag(ef0), .err_cnt(ec0), .word_cnt(wc0), .first_exp(fe0),
    .first_got(fg0), .first_idx(fi0));
  nios_altmemddr_0_ex_lfsr_gen_chk #(.STEPS(2)) u1 (.clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .pause(pause), .load(load), .ldata(ldata), .data(d1), .chk_valid(chk_valid),
    .chk_data(chk_data), .clr_err(clr_err), .err_flag(ef1), .err_cnt(ec1), .word_cnt(wc1),
    .first_exp(fe1), .first_got(fg1), .first_idx(fi1));
  nios_altmemddr_0_ex_lfsr_gen_chk #(.CNT_W(4)) u2 (.clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .pause(pause), .load(load), .ldata(ldata), .data(d2), .chk_valid(chk_valid),
    .chk_data(chk_data), .clr_err(clr_err), .err_flag(ef2), .err_cnt(ec2), .word_cnt(wc2),
    .first_exp(fe2), .first_got(fg2), .first_idx(fi2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; mode = 0; pause = 0; load = 0; ldata = 0;
    chk_valid = 0; chk_data = 0; clr_err = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d0 !== 8'h20) begin errors++; $display("FAIL reset_data: got %h exp 20", d0); end
    checks++; if (ef0 !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b exp 0", ef0); end
    checks++; if (ec0 !== 16'd0 || wc0 !== 16'd0) begin errors++;
      $display("FAIL reset_cnt: got err %0d word %0d exp 0 0", ec0, wc0); end
    checks++; if (fe0 !== 8'h0 || fg0 !== 8'h0 || fi0 !== 16'd0) begin errors++;
      $display("FAIL reset_first: got %h %h %0d exp 0 0 0", fe0, fg0, fi0); end
  endtask

  task automatic test_gen();
    logic [7:0] exp [8] = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};
    do_reset();
    enable = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (d0 !== exp[i]) begin errors++; $display("FAIL gen_seq[%0d]: got %h exp %h", i, d0, exp[i]); end
      tick();
    end
  endtask

  task automatic test_steps2();
    logic [7:0] exp [4] = '{8'h20, 8'h80, 8'h3A, 8'hE8};
    do_reset();
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (d1 !== exp[i]) begin errors++; $display("FAIL steps2_seq[%0d]: got %h exp %h", i, d1, exp[i]); end
      if (i < 3) tick();
    end
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d1 !== 8'hE8) begin errors++; $display("FAIL steps2_pause[%0d]: got %h exp e8", i, d1); end
    end
    enable = 0; pause = 0;
    tick();
    checks++; if (d1 !== 8'h20) begin errors++; $display("FAIL steps2_disable: got %h exp 20", d1); end
  endtask

  task automatic feed(input logic [7:0] w);
    chk_valid = 1; chk_data = w;
    tick();
    chk_valid = 0;
  endtask

  task automatic test_check();
    do_reset();
    enable = 1; mode = 1;
    tick();
    feed(8'h74);
    checks++; if (d0 !== 8'hE8) begin errors++; $display("FAIL chk_sync_data: got %h exp e8", d0); end
    checks++; if (wc0 !== 16'd0) begin errors++; $display("FAIL chk_sync_uncounted: got %0d exp 0", wc0); end
    feed(8'hE8); feed(8'hCD); feed(8'h87);
    checks++; if (wc0 !== 16'd3) begin errors++; $display("FAIL chk_word_cnt: got %0d exp 3", wc0); end
    checks++; if (ec0 !== 16'd0 || ef0 !== 1'b0) begin errors++;
      $display("FAIL chk_no_err: got cnt %0d flag %b exp 0 0", ec0, ef0); end
  endtask

  task automatic test_err();
    do_reset();
    enable = 1; mode = 1;
    tick();
    feed(8'h74); feed(8'hE8); feed(8'hCC); feed(8'h87);
    checks++; if (ec0 !== 16'd1 || ef0 !== 1'b1) begin errors++;
      $display("FAIL err_one: got cnt %0d flag %b exp 1 1", ec0, ef0); end
    checks++; if (fe0 !== 8'hCD || fg0 !== 8'hCC || fi0 !== 16'd1) begin errors++;
      $display("FAIL err_first: got exp=%h got=%h idx=%0d exp cd cc 1", fe0, fg0, fi0); end
    checks++; if (wc0 !== 16'd3) begin errors++; $display("FAIL err_word_cnt: got %0d exp 3", wc0); end
    feed(8'h00);
    checks++; if (ec0 !== 16'd2 || wc0 !== 16'd4) begin errors++;
      $display("FAIL err_two: got err %0d word %0d exp 2 4", ec0, wc0); end
    checks++; if (fe0 !== 8'hCD || fg0 !== 8'hCC || fi0 !== 16'd1) begin errors++;
      $display("FAIL err_first_held: got %h %h %0d exp cd cc 1", fe0, fg0, fi0); end
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1; mode = 1;
    tick();
    feed(8'h74);
    for (int i = 0; i < 20; i++) feed(8'h00);
    checks++; if (ec2 !== 4'd15 || wc2 !== 4'd15 || ef2 !== 1'b1) begin errors++;
      $display("FAIL sat_cnt: got err %0d word %0d flag %b exp 15 15 1", ec2, wc2, ef2); end
    clr_err = 1; chk_valid = 1; chk_data = 8'h00;
    tick();
    clr_err = 0; chk_valid = 0;
    checks++; if (ec2 !== 4'd0 || wc2 !== 4'd0 || ef2 !== 1'b0) begin errors++;
      $display("FAIL clr_cnt: got err %0d word %0d flag %b exp 0 0 0", ec2, wc2, ef2); end
    checks++; if (fe2 !== 8'h0 || fg2 !== 8'h0 || fi2 !== 4'd0) begin errors++;
      $display("FAIL clr_first: got %h %h %0d exp 0 0 0", fe2, fg2, fi2); end
  endtask

  task automatic test_load_reset();
    do_reset();
    enable = 1; mode = 1;
    tick();
    feed(8'h74); feed(8'hE8);
    load = 1; ldata = 8'h55; chk_valid = 1; chk_data = 8'h00;
    tick();
    load = 0; chk_valid = 0;
    checks++; if (d0 !== 8'h55) begin errors++; $display("FAIL load_data: got %h exp 55", d0); end
    checks++; if (wc0 !== 16'd1 || ec0 !== 16'd0) begin errors++;
      $display("FAIL load_no_count: got word %0d err %0d exp 1 0", wc0, ec0); end
    feed(8'h00);
    checks++; if (ec0 !== 16'd1 || fe0 !== 8'h55) begin errors++;
      $display("FAIL pre_reset_err: got err %0d first_exp %h exp 1 55", ec0, fe0); end
    reset = 1; chk_valid = 1; chk_data = 8'h00;
    tick();
    reset = 0; chk_valid = 0;
    checks++; if (d0 !== 8'h20 || ef0 !== 1'b0 || ec0 !== 16'd0 || wc0 !== 16'd0) begin errors++;
      $display("FAIL mid_reset: got data %h flag %b err %0d word %0d exp 20 0 0 0", d0, ef0, ec0, wc0); end
    checks++; if (fe0 !== 8'h0 || fg0 !== 8'h0 || fi0 !== 16'd0) begin errors++;
      $display("FAIL mid_reset_first: got %h %h %0d exp 0 0 0", fe0, fg0, fi0); end
  endtask

  initial begin
    test_reset();
    test_gen();
    test_steps2();
    test_check();
    test_err();
    test_saturate();
    test_load_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
